// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register, req/ack data-memory access, lane steering.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int DMEM_AW = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EX_vld,
  input  logic [31:0]        EX_alu_res,
  input  logic [31:0]        EX_mem_din,
  input  logic [1:0]         EX_mem_op,
  input  logic [2:0]         EX_mem_size,
  input  logic [4:0]         EX_rd,
  output logic               MEM_busy,
  output logic               MEM_vld,
  output logic [31:0]        MEM_data,
  output logic [4:0]         MEM_rd,
  output logic               MEM_wb_en,
  output logic               MEM_misaligned,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic [31:0] a_addr;
  logic [2:0]  a_size;
  logic [4:0]  a_rd;
  logic        a_st;

  logic        is_ld;
  logic        is_st;
  logic        is_mem;
  logic        trap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;
  logic [31:0] ld_data;

  assign is_ld    = (EX_mem_op == 2'b01);
  assign is_st    = (EX_mem_op == 2'b10);
  assign is_mem   = is_ld | is_st;
  assign MEM_busy = (state == ACCESS);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis;

  assign mis = ((EX_mem_size[1:0] == 2'b01) && EX_alu_res[0]) ||
               ((EX_mem_size == 3'b010) && (EX_alu_res[1:0] != 2'b00));
  assign trap = EX_vld && is_mem && mis;

  always_ff @(posedge clk) begin
    if (rst)
      MEM_misaligned <= 1'b0;
    else
      MEM_misaligned <= (state == IDLE) && trap;
  end
`else
  assign trap           = 1'b0;
  assign MEM_misaligned = 1'b0;
`endif

  // Store lanes; funct3 codes other than B/H store a full word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = EX_mem_din;
    case (EX_mem_size[1:0])
      2'b00: begin
        st_be    = 4'b0001 << EX_alu_res[1:0];
        st_wdata = {4{EX_mem_din[7:0]}};
      end
      2'b01: begin
        st_be    = EX_alu_res[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{EX_mem_din[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword lane ignores addr[0], so unaligned H loads truncate naturally.
  assign lane_h = a_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign lane_b = a_addr[0] ? lane_h[15:8] : lane_h[7:0];

  always_comb begin
    ld_data = dmem_rdata;
    case (a_size)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_data = {24'h0, lane_b};
      3'b101:  ld_data = {16'h0, lane_h};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_addr     <= '0;
      a_size     <= '0;
      a_rd       <= '0;
      a_st       <= 1'b0;
      MEM_vld    <= 1'b0;
      MEM_data   <= '0;
      MEM_rd     <= '0;
      MEM_wb_en  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      stall_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trap) begin
            MEM_vld   <= 1'b0;
            MEM_wb_en <= 1'b0;
            MEM_data  <= EX_alu_res;
          end else if (EX_vld && is_mem) begin
            state      <= ACCESS;
            MEM_vld    <= 1'b0;
            a_addr     <= EX_alu_res;
            a_size     <= EX_mem_size;
            a_rd       <= EX_rd;
            a_st       <= is_st;
            dmem_req   <= 1'b1;
            dmem_we    <= is_st;
            dmem_addr  <= {EX_alu_res[DMEM_AW-1:2], 2'b00};
            dmem_be    <= is_st ? st_be : 4'b1111;
            dmem_wdata <= st_wdata;
          end else if (EX_vld) begin
            MEM_vld   <= 1'b1;
            MEM_data  <= EX_alu_res;
            MEM_rd    <= EX_rd;
            MEM_wb_en <= (EX_rd != 5'd0);
          end else begin
            MEM_vld <= 1'b0;
          end
        end
        ACCESS: begin
          if (stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            MEM_vld  <= 1'b1;
            MEM_rd   <= a_rd;
            if (a_st) begin
              MEM_data  <= a_addr;
              MEM_wb_en <= 1'b0;
            end else begin
              MEM_data  <= ld_data;
              MEM_wb_en <= (a_rd != 5'd0);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table plus result scoreboard for mem_stage.
// Define MEM_MISALIGN_TRAP_EN for both files to exercise the trap build.
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EX_vld = 1'b0;
  logic [31:0] EX_alu_res = '0;
  logic [31:0] EX_mem_din = '0;
  logic [1:0]  EX_mem_op = '0;
  logic [2:0]  EX_mem_size = '0;
  logic [4:0]  EX_rd = '0;
  logic        MEM_busy;
  logic        MEM_vld;
  logic [31:0] MEM_data;
  logic [4:0]  MEM_rd;
  logic        MEM_wb_en;
  logic        MEM_misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] stall_cnt;

  mem_stage #(.DMEM_AW(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .EX_vld(EX_vld), .EX_alu_res(EX_alu_res), .EX_mem_din(EX_mem_din),
    .EX_mem_op(EX_mem_op), .EX_mem_size(EX_mem_size), .EX_rd(EX_rd),
    .MEM_busy(MEM_busy), .MEM_vld(MEM_vld), .MEM_data(MEM_data),
    .MEM_rd(MEM_rd), .MEM_wb_en(MEM_wb_en), .MEM_misaligned(MEM_misaligned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wb;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] din;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          wt;
    logic [31:0] ed;
    logic        ewb;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] eaddr;
  } vec_t;

  res_t        sb[$];
  res_t        mon_r;
  vec_t        tbl[24];
  int          n_vec = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] din,
                     input logic [4:0] rd, input logic [31:0] rdata,
                     input int wt, input logic [31:0] ed, input logic ewb,
                     input logic [3:0] ebe, input logic [31:0] ewd,
                     input logic [31:0] eaddr);
    vec_t v;
    v.op = op; v.sz = sz; v.a = a; v.din = din; v.rd = rd;
    v.rdata = rdata; v.wt = wt; v.ed = ed; v.ewb = ewb;
    v.ebe = ebe; v.ewd = ewd; v.eaddr = eaddr;
    tbl[n_vec] = v;
    n_vec++;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [4:0] rd,
                          input logic wb);
    res_t r;
    r.data = d; r.rd = rd; r.wb = wb;
    sb.push_back(r);
  endtask

  // Every MEM_vld pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && MEM_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got data %h want no result", MEM_data);
      end else begin
        mon_r = sb.pop_front();
        chk("mem_data", MEM_data, mon_r.data);
        chk("mem_rd", 32'(MEM_rd), 32'(mon_r.rd));
        chk("mem_wb_en", 32'(MEM_wb_en), 32'(mon_r.wb));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    bit mem;
    int busy_n;
    mem = (v.op == 2'b01) || (v.op == 2'b10);
    @(negedge clk);
    EX_vld = 1'b1; EX_mem_op = v.op; EX_mem_size = v.sz;
    EX_alu_res = v.a; EX_mem_din = v.din; EX_rd = v.rd;
    push_exp(v.ed, v.rd, v.ewb);
    @(negedge clk);
    EX_vld = 1'b0; EX_mem_op = 2'b00;
    if (mem) begin
      busy_n = 0;
      chk("dmem_req", 32'(dmem_req), 32'd1);
      chk("dmem_we", 32'(dmem_we), 32'(v.op == 2'b10));
      chk("dmem_addr", dmem_addr, v.eaddr);
      chk("dmem_be", 32'(dmem_be), 32'(v.ebe));
      if (v.op == 2'b10)
        chk("dmem_wdata", dmem_wdata, v.ewd);
      for (int i = 0; i <= v.wt; i++) begin
        if (MEM_busy && dmem_req && dmem_addr == v.eaddr)
          busy_n++;
        dmem_ack   = (i == v.wt);
        dmem_rdata = (i == v.wt) ? v.rdata : ~v.rdata;
        @(negedge clk);
      end
      dmem_ack = 1'b0;
      exp_stall += 32'(v.wt + 1);
      chk("busy_cycles", 32'(busy_n), 32'(v.wt + 1));
      chk("busy_clear", 32'(MEM_busy), 32'd0);
      chk("req_clear", 32'(dmem_req), 32'd0);
      chk("stall_cnt", stall_cnt, exp_stall);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add(2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 32'h0, 0,
        32'h1234_5678, 1'b1, 4'h0, 32'h0, 32'h0);
    add(2'b00, 3'b000, 32'hCAFE_F00D, 32'h0, 5'd0, 32'h0, 0,
        32'hCAFE_F00D, 1'b0, 4'h0, 32'h0, 32'h0);
    add(2'b11, 3'b010, 32'h0000_00FF, 32'h0, 5'd7, 32'h0, 0,
        32'h0000_00FF, 1'b1, 4'h0, 32'h0, 32'h0);
    add(2'b01, 3'b000, 32'h0000_0103, 32'h0, 5'd10, 32'h80AA_BBCC, 3,
        32'hFFFF_FF80, 1'b1, 4'hF, 32'h0, 32'h0000_0100);
    add(2'b10, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 32'h0, 0,
        32'h0000_0202, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0200);
    add(2'b01, 3'b101, 32'h0000_0002, 32'h0, 5'd4, 32'h8001_0000, 1,
        32'h0000_8001, 1'b1, 4'hF, 32'h0, 32'h0);
    add(2'b01, 3'b001, 32'h0000_0002, 32'h0, 5'd4, 32'h8001_0000, 2,
        32'hFFFF_8001, 1'b1, 4'hF, 32'h0, 32'h0);
    add(2'b01, 3'b100, 32'h0000_0001, 32'h0, 5'd11, 32'h1234_8856, 0,
        32'h0000_0088, 1'b1, 4'hF, 32'h0, 32'h0);
    add(2'b01, 3'b010, 32'h0000_0040, 32'h0, 5'd0, 32'hA5A5_5A5A, 1,
        32'hA5A5_5A5A, 1'b0, 4'hF, 32'h0, 32'h0000_0040);
    add(2'b10, 3'b000, 32'h0000_0013, 32'h0000_00AB, 5'd1, 32'h0, 2,
        32'h0000_0013, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0000_0010);
    add(2'b10, 3'b010, 32'h0000_0020, 32'h0123_4567, 5'd2, 32'h0, 0,
        32'h0000_0020, 1'b0, 4'hF, 32'h0123_4567, 32'h0000_0020);
    add(2'b01, 3'b001, 32'h0000_0004, 32'h0, 5'd12, 32'h1234_7FFF, 0,
        32'h0000_7FFF, 1'b1, 4'hF, 32'h0, 32'h0000_0004);
    add(2'b01, 3'b011, 32'h0000_0008, 32'h0, 5'd12, 32'hDEAD_BEEF, 1,
        32'hDEAD_BEEF, 1'b1, 4'hF, 32'h0, 32'h0000_0008);
    add(2'b01, 3'b000, 32'h0000_0102, 32'h0, 5'd13, 32'h007F_0000, 0,
        32'h0000_007F, 1'b1, 4'hF, 32'h0, 32'h0000_0100);
`ifndef MEM_MISALIGN_TRAP_EN
    add(2'b01, 3'b010, 32'h0000_0006, 32'h0, 5'd14, 32'hCAFE_BABE, 1,
        32'hCAFE_BABE, 1'b1, 4'hF, 32'h0, 32'h0000_0004);
    add(2'b01, 3'b001, 32'h0000_0003, 32'h0, 5'd15, 32'hF00D_1234, 0,
        32'hFFFF_F00D, 1'b1, 4'hF, 32'h0, 32'h0);
    add(2'b10, 3'b001, 32'h0000_0003, 32'h0000_ABCD, 5'd9, 32'h0, 1,
        32'h0000_0003, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(MEM_vld), 32'd0);
    chk("rst_data", MEM_data, 32'd0);
    chk("rst_busy", 32'(MEM_busy), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_mis", 32'(MEM_misaligned), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < n_vec; k++)
      run_vec(tbl[k]);

    // Load then an ALU op held by EX during the stall.
    @(negedge clk);
    EX_vld = 1'b1; EX_mem_op = 2'b01; EX_mem_size = 3'b010;
    EX_alu_res = 32'h0000_0030; EX_rd = 5'd6;
    push_exp(32'h1122_3344, 5'd6, 1'b1);
    @(negedge clk);
    EX_mem_op = 2'b00; EX_alu_res = 32'h0000_55AA; EX_rd = 5'd7;
    push_exp(32'h0000_55AA, 5'd7, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    @(negedge clk);
    dmem_ack = 1'b0;
    exp_stall += 32'd1;
    chk("b2b_load_vld", 32'(MEM_vld), 32'd1);
    chk("b2b_load_data", MEM_data, 32'h1122_3344);
    @(negedge clk);
    EX_vld = 1'b0;
    chk("b2b_alu_vld", 32'(MEM_vld), 32'd1);
    chk("b2b_alu_data", MEM_data, 32'h0000_55AA);
    chk("b2b_stall", stall_cnt, exp_stall);
    @(negedge clk);
    chk("b2b_idle_vld", 32'(MEM_vld), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    EX_vld = 1'b1; EX_mem_op = 2'b01; EX_mem_size = 3'b010;
    EX_alu_res = 32'h0000_0006; EX_rd = 5'd9;
    @(negedge clk);
    EX_vld = 1'b0; EX_mem_op = 2'b00;
    chk("trap_mis", 32'(MEM_misaligned), 32'd1);
    chk("trap_req", 32'(dmem_req), 32'd0);
    chk("trap_busy", 32'(MEM_busy), 32'd0);
    chk("trap_vld", 32'(MEM_vld), 32'd0);
    chk("trap_wb", 32'(MEM_wb_en), 32'd0);
    chk("trap_data", MEM_data, 32'h0000_0006);
    @(negedge clk);
    chk("trap_mis_pulse", 32'(MEM_misaligned), 32'd0);
    chk("trap_stall", stall_cnt, exp_stall);
`endif

    // Reset during ACCESS, with a late ack that must be ignored.
    @(negedge clk);
    EX_vld = 1'b1; EX_mem_op = 2'b10; EX_mem_size = 3'b010;
    EX_alu_res = 32'h0000_0080; EX_mem_din = 32'h5555_AAAA; EX_rd = 5'd8;
    @(negedge clk);
    EX_vld = 1'b0; EX_mem_op = 2'b00;
    chk("abort_req_set", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    exp_stall = '0;
    chk("abort_req", 32'(dmem_req), 32'd0);
    chk("abort_busy", 32'(MEM_busy), 32'd0);
    chk("abort_vld", 32'(MEM_vld), 32'd0);
    chk("abort_wb", 32'(MEM_wb_en), 32'd0);
    chk("abort_stall", stall_cnt, exp_stall);
    @(negedge clk);
    chk("abort_vld_hold", 32'(MEM_vld), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Downstream partner of the execute stage. Registers the EX/MEM pipeline boundary and passes ALU results through in one cycle.
- Runs loads and stores to the data memory over a req/ack handshake, with byte/halfword lane steering and sign/zero extension.
- Drives the MEM_data forwarding value and the MEM_busy stall back upstream.

Parameters:
- DMEM_AW, 32, data-memory byte address width. dmem_addr is word-aligned, so bits [1:0] are always 0.
- CNT_W, 32, width of the memory-stall cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- EX_vld  in  1  EX result valid
- EX_alu_res  in  32  ALU result, or effective address for memory ops
- EX_mem_din  in  32  store data
- EX_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- EX_mem_size  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- EX_rd  in  5  destination register
- MEM_busy  out  1  stall to EX/ID; EX holds its outputs while high
- MEM_vld  out  1  registered result valid
- MEM_data  out  32  registered result / forwarding value
- MEM_rd  out  5  registered destination
- MEM_wb_en  out  1  result writes the register file (0 for stores)
- MEM_misaligned  out  1  misaligned-access pulse (optional feature only)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DMEM_AW  word address, low 2 bits zero
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  request complete; rdata valid in the same cycle
- dmem_rdata  in  32  read word
- stall_cnt  out  CNT_W  number of cycles spent in ACCESS

Behaviour:
- Reset (synchronous): all outputs go to 0 and the state goes to IDLE. An ack arriving after reset is ignored.
- States: IDLE and ACCESS. MEM_busy = (state == ACCESS), decoded from registered state.
- IDLE, EX_vld=1, op none: at the edge MEM_vld<=1, MEM_data<=EX_alu_res, MEM_rd<=EX_rd, MEM_wb_en<=(EX_rd!=0). Latency 1 cycle.
- IDLE, EX_vld=0: MEM_vld<=0.
- IDLE, load/store: at the edge the block latches addr, data, size, rd and op, goes to ACCESS, and sets MEM_vld<=0. The request registers are set as follows:
  - dmem_req<=1
  - dmem_we<=(op==store)
  - dmem_addr<={addr[DMEM_AW-1:2],2'b00}
  - dmem_be and dmem_wdata from the lane rules below.
- ACCESS, dmem_ack=0: request signals held stable; stall_cnt increments and saturates at all-ones.
- ACCESS, dmem_ack=1 (the ack cycle still counts toward stall_cnt): at the edge dmem_req<=0, state<=IDLE, MEM_vld<=1, MEM_rd<=latched rd. Then:
  - Load: MEM_data<=extended lane, MEM_wb_en<=(rd!=0).
  - Store: MEM_data<=address, MEM_wb_en<=0.
- EX input is never sampled in ACCESS, including the ack cycle, so back-to-back memory ops have a minimum spacing of 2 cycles.
- Store lanes:
  - B: be = 4'b0001 << addr[1:0], wdata = {4{din[7:0]}}
  - H: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{din[15:0]}}
  - W: be = 4'b1111, wdata = din
- Load lanes: lane = rdata >> (8*addr[1:0]).
  - B / H: sign-extend bit 7 / bit 15.
  - BU / HU: zero-extend.
  - W: rdata unchanged.
  - Undefined size codes behave as W.
- Loads drive dmem_be = 4'b1111.
- rst asserted in ACCESS aborts the access: no result and no write-back.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Defined: a misaligned memory op in IDLE issues no request and stays in IDLE. At the edge, MEM_misaligned<=1 for 1 cycle, MEM_vld<=0, MEM_wb_en<=0, MEM_data<=faulting address.
- Undefined: MEM_misaligned is tied 0, and the address is truncated to natural alignment (H ignores addr[0]; W ignores addr[1:0]).

Test Plan:
- ALU pass-through: EX_vld=1, op none, alu_res=0x1234_5678, rd=5 -> next cycle MEM_vld=1, MEM_data=0x12345678, MEM_rd=5, wb_en=1, MEM_busy=0.
- Load byte, signed: addr=0x103, LB, ack after 3 wait cycles with rdata=0x80AA_BBCC -> dmem_addr=0x100, dmem_be=1111; MEM_busy high 4 cycles; MEM_data=0xFFFF_FF80; stall_cnt=4.
- Store half: addr=0x202, SH, din=0xDEAD_BEEF, ack in 1st cycle -> dmem_we=1, dmem_be=1100, dmem_wdata=0xBEEF_BEEF; MEM_wb_en=0.
- LHU at addr=0x2 with rdata=0x8001_0000 -> MEM_data=0x0000_8001. LW back-to-back with a following ALU op -> ALU result appears 1 cycle after the load result.
- Reset mid-access: rst during ACCESS, then ack the following cycle -> dmem_req=0, state IDLE, MEM_vld stays 0, stall_cnt=0.
- With MEM_MISALIGN_TRAP_EN, LW addr=0x6 -> no dmem_req, MEM_misaligned=1 for 1 cycle, MEM_data=0x6. Without it -> dmem_addr=0x4, normal load.
